clk_div_ctrl: RTL and testbench

Multi-channel clock-enable controller for the scoreboard. It replaces free-running per-module dividers with CH programmable dividers. Each channel emits a one-cycle TICK strobe every DIV cycles of the system clock. Divider ratio and enable are reconfigured at runtime through a valid/ready port, and updates to a running channel are applied glitch-free at that channel's next wrap.

---
 rtl/clk_div_ctrl.sv | 127 ++++++++++++
 tb/tb_clk_div_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Multi-channel programmable clock-enable generator: each running channel strobes TICK
// once every div cycles. A retune of a running channel is held back until that channel wraps.
module clk_div_ctrl #(
  parameter int          W           = 16,
  parameter int          CH          = 4,
  parameter int          CHW         = 2,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           SYNC,
  input  logic           CFG_VALID,
  output logic           CFG_READY,
  input  logic [CHW-1:0] CFG_CH,
  input  logic [W-1:0]   CFG_DIV,
  input  logic           CFG_EN,
  output logic [CH-1:0]  TICK,
  output logic [CH-1:0]  ACTIVE
);

  localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t         state;
  logic [W-1:0]   cnt [CH];
  logic [W-1:0]   div [CH];
  logic [CH-1:0]  en;
  logic [CH-1:0]  tick_r;
  logic [CH-1:0]  active_r;
  logic [W-1:0]   pend_div;
  logic [CHW-1:0] pend_ch;

  logic [CH-1:0]  running;
  logic [CH-1:0]  wrap;
  logic [CH-1:0]  sel;
  logic [CH-1:0]  defer;
  logic [CH-1:0]  apply_now;
  logic [CH-1:0]  commit;
  logic           fire;
  logic           new_run;

  function automatic logic is_wrap(input logic [W-1:0] c, input logic [W-1:0] d);
    return c == (d - W'(1));
  endfunction

  assign CFG_READY = (state == ST_IDLE);
  assign fire      = CFG_VALID && (state == ST_IDLE);
  assign new_run   = CFG_EN && (CFG_DIV != '0);
  assign TICK      = tick_r;
  assign ACTIVE    = active_r;

  // Out-of-range channel indices never match any sel bit, so they are silently dropped.
  always_comb begin
    running   = '0;
    wrap      = '0;
    sel       = '0;
    defer     = '0;
    apply_now = '0;
    commit    = '0;
    for (int i = 0; i < CH; i++) begin
      running[i]   = en[i] && (div[i] != '0);
      wrap[i]      = is_wrap(cnt[i], div[i]);
      sel[i]       = fire && (CFG_CH == CHW'(i));
      defer[i]     = sel[i] && running[i] && new_run;
      apply_now[i] = sel[i] && !defer[i];
      commit[i]    = (state == ST_WAIT) && (pend_ch == CHW'(i)) && (SYNC || wrap[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= ST_IDLE;
      pend_div <= '0;
      pend_ch  <= '0;
      en       <= '0;
      tick_r   <= '0;
      active_r <= '0;
      for (int i = 0; i < CH; i++) begin
        cnt[i] <= '0;
        div[i] <= DEF_DIV;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        active_r[i] <= running[i];
        if (apply_now[i]) begin
          en[i]     <= CFG_EN;
          div[i]    <= CFG_DIV;
          cnt[i]    <= '0;
          tick_r[i] <= 1'b0;
        end else if (SYNC) begin
          // SYNC wins over a coincident wrap: no strobe on this edge.
          cnt[i]    <= '0;
          tick_r[i] <= 1'b0;
          if (commit[i]) div[i] <= pend_div;
        end else if (running[i]) begin
          if (wrap[i]) begin
            cnt[i]    <= '0;
            tick_r[i] <= 1'b1;
            if (commit[i]) div[i] <= pend_div;
          end else begin
            cnt[i]    <= cnt[i] + W'(1);
            tick_r[i] <= 1'b0;
          end
        end else begin
          cnt[i]    <= '0;
          tick_r[i] <= 1'b0;
        end
      end

      case (state)
        ST_IDLE: begin
          if (|defer) begin
            state    <= ST_WAIT;
            pend_div <= CFG_DIV;
            pend_ch  <= CFG_CH;
          end
        end
        ST_WAIT: begin
          if (|commit) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: expected ticks and ACTIVE/CFG_READY levels are queued
// by the stimulus and matched by a negedge monitor.
module tb_clk_div_ctrl;

  localparam int W   = 16;
  localparam int CH  = 4;
  localparam int CHW = 3;

  logic           CLK       = 1'b0;
  logic           RST       = 1'b0;
  logic           SYNC      = 1'b0;
  logic           CFG_VALID = 1'b0;
  logic           CFG_READY;
  logic [CHW-1:0] CFG_CH    = '0;
  logic [W-1:0]   CFG_DIV   = '0;
  logic           CFG_EN    = 1'b0;
  logic [CH-1:0]  TICK;
  logic [CH-1:0]  ACTIVE;

  clk_div_ctrl #(.W(W), .CH(CH), .CHW(CHW), .DEFAULT_DIV(10)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SYNC      (SYNC),
    .CFG_VALID (CFG_VALID),
    .CFG_READY (CFG_READY),
    .CFG_CH    (CFG_CH),
    .CFG_DIV   (CFG_DIV),
    .CFG_EN    (CFG_EN),
    .TICK      (TICK),
    .ACTIVE    (ACTIVE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int ch;
    int cyc;
  } tick_t;

  typedef struct {
    int            cyc;
    logic [CH-1:0] act;
    logic          rdy;
  } lvl_t;

  tick_t tick_q[$];
  lvl_t  lvl_q[$];
  int    total  = 0;
  int    passed = 0;

  task automatic exp_tick(input int ch, input int c);
    tick_t e;
    e.ch  = ch;
    e.cyc = c;
    tick_q.push_back(e);
  endtask

  task automatic exp_lvl(input int c, input logic [CH-1:0] a, input logic r);
    lvl_t e;
    e.cyc = c;
    e.act = a;
    e.rdy = r;
    lvl_q.push_back(e);
  endtask

  // Called at a falling edge; the transfer happens on the next rising edge (cyc+1).
  task automatic cfg(input int ch, input int dv, input logic e);
    CFG_CH    = CHW'(ch);
    CFG_DIV   = W'(dv);
    CFG_EN    = e;
    CFG_VALID = 1'b1;
    @(negedge CLK);
    CFG_VALID = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic do_reset(input int n);
    RST = 1'b0;
    repeat (n) @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic pulse_sync();
    SYNC = 1'b1;
    @(negedge CLK);
    SYNC = 1'b0;
  endtask

  // Monitor
  always @(negedge CLK) begin : mon
    int hit;
    for (int c = 0; c < CH; c++) begin
      if (TICK[c] !== 1'b0) begin
        hit = -1;
        for (int k = 0; k < tick_q.size(); k++)
          if (tick_q[k].ch == c && tick_q[k].cyc == cyc) hit = k;
        total++;
        if (hit >= 0) begin
          passed++;
          tick_q.delete(hit);
        end else begin
          $display("FAIL tick_unexpected: TICK[%0d]=%b at cycle %0d, required 0", c, TICK[c], cyc);
        end
      end
    end
    for (int k = tick_q.size() - 1; k >= 0; k--) begin
      if (tick_q[k].cyc < cyc) begin
        total++;
        $display("FAIL tick_missing: TICK[%0d]=0 at cycle %0d, required 1", tick_q[k].ch, tick_q[k].cyc);
        tick_q.delete(k);
      end
    end
    for (int k = lvl_q.size() - 1; k >= 0; k--) begin
      if (lvl_q[k].cyc <= cyc) begin
        total++;
        if (lvl_q[k].cyc == cyc && ACTIVE === lvl_q[k].act && CFG_READY === lvl_q[k].rdy)
          passed++;
        else
          $display("FAIL level@%0d: ACTIVE=%b CFG_READY=%b, required ACTIVE=%b CFG_READY=%b",
                   lvl_q[k].cyc, ACTIVE, CFG_READY, lvl_q[k].act, lvl_q[k].rdy);
        lvl_q.delete(k);
      end
    end
  end

  initial begin : stim
    int t;
    int s;

    // Reset held for 5 edges, then enable ch0 at div 10
    exp_lvl(1, 4'b0000, 1'b1);
    exp_lvl(4, 4'b0000, 1'b1);
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    t = cyc + 1;
    exp_lvl(t, 4'b0000, 1'b1);
    exp_lvl(t + 1, 4'b0001, 1'b1);
    exp_tick(0, t + 10);
    exp_tick(0, t + 20);
    exp_tick(0, t + 30);
    exp_lvl(t + 30, 4'b0001, 1'b1);
    cfg(0, 10, 1'b1);
    wait_cyc(t + 31);
    do_reset(2);

    // Retune running ch0 from 10 to 4 while cnt=3
    t = cyc + 1;
    exp_lvl(t + 1, 4'b0001, 1'b1);
    cfg(0, 10, 1'b1);
    wait_cyc(t + 2);
    exp_lvl(t + 3, 4'b0001, 1'b0);
    exp_lvl(t + 9, 4'b0001, 1'b0);
    exp_lvl(t + 10, 4'b0001, 1'b1);
    exp_tick(0, t + 10);
    exp_tick(0, t + 14);
    exp_tick(0, t + 18);
    cfg(0, 4, 1'b1);
    wait_cyc(t + 19);
    do_reset(1);

    // div=1 ticks every cycle; div=0 stays stopped even when enabled
    t = cyc + 1;
    for (int k = 1; k <= 8; k++) exp_tick(1, t + k);
    exp_lvl(t + 3, 4'b0010, 1'b1);
    cfg(1, 1, 1'b1);
    cfg(2, 0, 1'b1);
    wait_cyc(t + 8);
    do_reset(1);

    // Maximum ratio 2^W-1
    t = cyc + 1;
    exp_lvl(t + 2, 4'b1000, 1'b1);
    exp_tick(3, t + 65535);
    exp_lvl(t + 65535, 4'b1000, 1'b1);
    cfg(3, 65535, 1'b1);
    wait_cyc(t + 65535);
    do_reset(1);

    // SYNC realigns ch0 (div 6) and ch1 (div 3) and suppresses ch1's coincident wrap
    t = cyc + 1;
    exp_tick(1, t + 4);
    exp_tick(0, t + 6);
    exp_tick(1, t + 7);
    cfg(0, 6, 1'b1);
    cfg(1, 3, 1'b1);
    s = t + 10;
    wait_cyc(s - 1);
    exp_lvl(s, 4'b0011, 1'b1);
    exp_tick(1, s + 3);
    exp_tick(0, s + 6);
    exp_tick(1, s + 6);
    pulse_sync();
    wait_cyc(s + 7);
    do_reset(1);

    // Invalid channel index ignored; disabling a running channel is immediate
    t = cyc + 1;
    exp_lvl(t + 3, 4'b0011, 1'b1);
    exp_lvl(t + 5, 4'b0011, 1'b1);
    exp_lvl(t + 6, 4'b0010, 1'b1);
    exp_tick(1, t + 4);
    exp_tick(1, t + 7);
    exp_tick(1, t + 10);
    exp_tick(1, t + 13);
    cfg(0, 10, 1'b1);
    cfg(1, 3, 1'b1);
    cfg(5, 7, 1'b1);
    wait_cyc(t + 4);
    cfg(0, 10, 1'b0);
    wait_cyc(t + 13);
    do_reset(1);

    // Reset during WAIT drops the pending retune
    t = cyc + 1;
    cfg(0, 10, 1'b1);
    wait_cyc(t + 2);
    exp_lvl(t + 3, 4'b0001, 1'b0);
    cfg(0, 4, 1'b1);
    wait_cyc(t + 4);
    exp_lvl(t + 5, 4'b0000, 1'b1);
    do_reset(2);
    t = cyc + 1;
    exp_lvl(t, 4'b0000, 1'b1);
    exp_tick(0, t + 10);
    cfg(0, 10, 1'b1);
    wait_cyc(t + 12);
    do_reset(1);
    repeat (3) @(negedge CLK);

    total++;
    if (tick_q.size() == 0 && lvl_q.size() == 0) passed++;
    else $display("FAIL queue_drain: %0d ticks and %0d levels left, required 0 and 0",
                  tick_q.size(), lvl_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
